// File: rtl/melody_if.sv
// Control/status bundle between user-control logic and the melody sequencer.
// The control side drives the master modport; the sequencer is the slave.
interface melody_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop_en;
  logic [IDX_W-1:0] note_index;
  logic             beep_en;
  logic             note_start;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, loop_en,
    input  note_index, beep_en, note_start, busy, done
  );

  modport slave (
    input  start, stop, pause, loop_en,
    output note_index, beep_en, note_start, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps the note LUT index through a tune, one fixed beat per note with a
// trailing silent gap; supports start, stop, pause and looping.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000,
  parameter int NOTE_NUM    = 32,
  parameter int IDX_W       = 5
) (
  input  logic     clk,
  input  logic     rst,
  melody_if.slave  bus
);
  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] AUD_END =
    CW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [CW-1:0] BEAT_END =
    CW'(BEAT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NOTE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP,
    PAUSE
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             saved, saved_n;
  logic             beep, beep_n;
  logic             ns, ns_n;
  logic             done, done_n;
  logic             busy;
  logic             in_gap;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    saved_n = saved;
    beep_n  = 1'b0;
    ns_n    = 1'b0;
    done_n  = 1'b0;
    // a resuming PAUSE performs the step of the phase it froze
    in_gap  = (state == GAP) ||
              (state == PAUSE && saved);
    if (bus.stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state_n = PLAY;
        cnt_n   = '0;
        beep_n  = 1'b1;
        ns_n    = 1'b1;
      end
    end else if (bus.pause) begin
      state_n = PAUSE;
      if (state != PAUSE) saved_n = (state == GAP);
    end else if (!in_gap) begin
      cnt_n = cnt + CW'(1);
      if (cnt == AUD_END) begin
        state_n = GAP;
      end else begin
        state_n = PLAY;
        beep_n  = 1'b1;
      end
    end else if (cnt == BEAT_END) begin
      cnt_n = '0;
      if (idx != LAST) begin
        state_n = PLAY;
        idx_n   = idx + IDX_W'(1);
        beep_n  = 1'b1;
        ns_n    = 1'b1;
      end else if (bus.loop_en) begin
        state_n = PLAY;
        idx_n   = '0;
        beep_n  = 1'b1;
        ns_n    = 1'b1;
      end else begin
        state_n = IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end
    end else begin
      state_n = GAP;
      cnt_n   = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      saved <= 1'b0;
      beep  <= 1'b0;
      ns    <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      saved <= saved_n;
      beep  <= beep_n;
      ns    <= ns_n;
      done  <= done_n;
      busy  <= (state_n != IDLE);
    end
  end

  assign bus.note_index = idx;
  assign bus.beep_en    = beep;
  assign bus.note_start = ns;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a short 4-note, 8-cycle-beat tune.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_melody_sequencer;
  localparam int BEAT = 8;
  localparam int GAPC = 2;
  localparam int NN   = 4;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  logic [5:0] obs;

  melody_if #(.IDX_W(IW)) bus ();

  melody_sequencer #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAPC),
    .NOTE_NUM   (NN),
    .IDX_W      (IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.note_index, bus.beep_en,
                bus.note_start, bus.busy, bus.done};

  // {idx, beep_en, note_start, busy, done} i cycles after the first beep
  function automatic logic [5:0] slot_exp(input int i);
    logic [IW-1:0] ix;
    logic b, s;
    if (i >= NN * BEAT) return 6'b000001;
    ix = IW'(i / BEAT);
    b  = ((i % BEAT) < (BEAT - GAPC));
    s  = ((i % BEAT) == 0);
    return {ix, b, s, 1'b1, 1'b0};
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== 6'b0)
      $display("FAIL reset_initial got=%b exp=%b", obs, 6'b0);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    total++;
    if (obs !== slot_exp(3))
      $display("FAIL reset_preplay got=%b exp=%b", obs, slot_exp(3));
    else passed++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs !== 6'b0)
      $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 6'b0)
        $display("FAIL reset_idle[%0d] got=%b exp=%b", i, obs, 6'b0);
      else passed++;
    end
  endtask

  task automatic run_tune(input string tag, input int poke);
    logic [5:0] e;
    pulse_start();
    for (int i = 0; i <= NN * BEAT; i++) begin
      e = slot_exp(i);
      total++;
      if (obs !== e)
        $display("FAIL %s[%0d] got=%b exp=%b", tag, i, obs, e);
      else passed++;
      bus.start = (i == poke);
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (obs !== 6'b0)
      $display("FAIL %s_after got=%b exp=%b", tag, obs, 6'b0);
    else passed++;
  endtask

  task automatic test_single_tune();
    run_tune("single", -1);
  endtask

  task automatic test_loop();
    logic [5:0] e;
    bus.loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i <= 2 * NN * BEAT; i++) begin
      e = (i < 2 * NN * BEAT) ? slot_exp(i % (NN * BEAT))
                              : slot_exp(NN * BEAT);
      total++;
      if (obs !== e)
        $display("FAIL loop[%0d] got=%b exp=%b", i, obs, e);
      else passed++;
      if (i == 50) bus.loop_en = 1'b0;
      @(negedge clk);
    end
    total++;
    if (obs !== 6'b0)
      $display("FAIL loop_after got=%b exp=%b", obs, 6'b0);
    else passed++;
  endtask

  task automatic test_pause();
    logic [5:0] e;
    pulse_start();
    for (int i = 0; i <= NN * BEAT + 5; i++) begin
      if (i <= 10)      e = slot_exp(i);
      else if (i <= 15) e = 6'b010010;
      else              e = slot_exp(i - 5);
      total++;
      if (obs !== e)
        $display("FAIL pause[%0d] got=%b exp=%b", i, obs, e);
      else passed++;
      bus.pause = (i >= 10 && i <= 14);
      @(negedge clk);
    end
    bus.pause = 1'b0;
    total++;
    if (obs !== 6'b0)
      $display("FAIL pause_after got=%b exp=%b", obs, 6'b0);
    else passed++;
  endtask

  task automatic test_stop_start();
    logic [5:0] e;
    pulse_start();
    for (int i = 0; i <= 22; i++) begin
      e = slot_exp(i);
      total++;
      if (obs !== e)
        $display("FAIL stop_run[%0d] got=%b exp=%b", i, obs, e);
      else passed++;
      if (i == 22) begin
        bus.stop  = 1'b1;
        bus.start = 1'b1;
      end
      @(negedge clk);
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== 6'b0)
        $display("FAIL stop_idle[%0d] got=%b exp=%b", i, obs, 6'b0);
      else passed++;
      @(negedge clk);
    end
    pulse_start();
    total++;
    if (obs !== slot_exp(0))
      $display("FAIL stop_restart got=%b exp=%b", obs, slot_exp(0));
    else passed++;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    total++;
    if (obs !== 6'b0)
      $display("FAIL stop_final got=%b exp=%b", obs, 6'b0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_tune("busy_start", 10);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop_en = 1'b0;
    test_reset();
    test_single_tune();
    test_loop();
    test_pause();
    test_stop_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Sequences the note lookup table for the beep path. It steps the note index through a tune of NOTE_NUM entries, holding each note for a fixed beat and inserting a silent articulation gap between notes. It gates the square-wave divider through beep_en and supports start, stop, pause and loop. It sits between the user-control logic (keys/debounce) and the note LUT plus frequency divider.

Parameters:
BEAT_CYCLES, 12500000, clk cycles per note slot (250 ms at 50 MHz); includes the gap
GAP_CYCLES, 1250000, silent cycles at the end of each slot; constraint 1 <= GAP_CYCLES < BEAT_CYCLES
NOTE_NUM, 32, notes in the tune; constraint 2 <= NOTE_NUM <= 2^IDX_W
IDX_W, 5, width of note_index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse: begin playback from note 0
stop  in  1  one-cycle pulse: abort playback, return to idle
pause  in  1  level: freeze playback while high
loop_en  in  1  level: sampled at end of last note; 1 = wrap to note 0
note_index  out  IDX_W  LUT address of the current note
beep_en  out  1  1 = divider output audible
note_start  out  1  one-cycle pulse at the first audible cycle of each note (divider phase reload)
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle pulse when a non-looping tune completes

Behaviour:
- Reset is asynchronous and active-low; it is already decided. While rst=0: state=IDLE, slot counter=0, note_index=0, beep_en=0, note_start=0, busy=0, done=0. Reset mid-playback clears everything immediately, with no clock edge needed.
- All outputs are registered. Slot counter width is $clog2(BEAT_CYCLES).
- States: IDLE, PLAY, GAP, PAUSE.
- IDLE: beep_en=0, note_index=0.
  - start=1 -> PLAY. On the next edge: counter=0, beep_en=1, note_start=1, busy=1.
  - pause and loop_en are ignored.
- PLAY: beep_en=1.
  - The counter increments each cycle.
  - When counter == BEAT_CYCLES-GAP_CYCLES-1: go to GAP and increment the counter.
  - Audible length per note = BEAT_CYCLES-GAP_CYCLES cycles.
- GAP: beep_en=0. The counter increments.
  - When counter == BEAT_CYCLES-1: counter <= 0.
  - If note_index != NOTE_NUM-1: note_index+1 -> PLAY, with note_start pulse.
  - If last note and loop_en=1: note_index <= 0 -> PLAY, with note_start pulse, and no done.
  - If last note and loop_en=0: note_index <= 0 -> IDLE, done=1 for one cycle, busy=0.
- PAUSE: entered from PLAY or GAP when pause=1.
  - beep_en=0. Counter and note_index are frozen. The originating phase is saved in a 1-bit register.
  - pause=0 -> return to the saved phase. The counter continues from its frozen value.
  - Resuming into PLAY re-asserts beep_en with no note_start pulse.
  - Total audible cycles per note are unchanged by pausing.
- Priority, highest first: stop > pause > slot-end transition.
  - stop in any state -> IDLE, note_index=0, counter=0, beep_en=0, done=0.
  - stop and start in the same cycle -> IDLE.
  - start while busy is ignored.
  - pause in the same cycle as the slot end -> PAUSE. The slot-end transition happens on the first resumed cycle.
- note_start and done never assert in the same cycle.
- note_index is stable for the whole slot, including the gap and pauses.

Test Plan:
(Bench overrides: BEAT_CYCLES=8, GAP_CYCLES=2, NOTE_NUM=4, IDX_W=2.)
1. Assert rst=0 asynchronously mid-cycle during PLAY -> all outputs 0 immediately. Release rst, apply no start -> outputs stay 0.
2. One start pulse, loop_en=0 -> note_index 0,1,2,3, each held 8 cycles. beep_en high 6 cycles then low 2 each slot. note_start pulses 4 times, 8 cycles apart. done pulses once, 32 cycles after the first beep_en. busy falls with done.
3. loop_en=1, start -> after note 3's gap, note_index=0 with a note_start pulse; no done. Drop loop_en during note 2 -> tune ends after note 3 with done.
4. pause high for 5 cycles starting at PLAY counter=3 of note 1 -> beep_en low 5 cycles, note_index stays 1. After release, 3 more audible cycles (6 total), then the 2-cycle gap, then note 2. No extra note_start.
5. stop and start together during the GAP of note 2 -> IDLE, note_index=0, busy=0, no done. A later start restarts at note 0 with a note_start pulse.
6. start pulse while busy in PLAY of note 1 -> ignored. Sequence timing is identical to scenario 2.
